cl_to_axis_video: RTL and testbench

//  Consumes the Camera Link base-config word CL_data[27:0] = {spare, DVAL, FVAL, LVAL, pixel[23:0]}
//  and emits an AXI4-Stream video stream, in the same CL_clk domain: tuser = start of frame, tlast = end of line.

---
 rtl/cl_video_pkg.sv | 25 ++
 rtl/cl_axis_fifo.sv | 62 ++++++
 rtl/cl_to_axis_video.sv | 221 ++++++++++++++++++++++
 tb/tb_cl_to_axis_video.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_video_pkg.sv
// Shared definitions for the Camera Link to AXI4-Stream video bridge:
// CL word bit positions, FSM state encoding and the FIFO entry layout.
package cl_video_pkg;

    localparam int unsigned CL_WORD_W   = 28;
    localparam int unsigned CL_DVAL_BIT = 26;
    localparam int unsigned CL_FVAL_BIT = 25;
    localparam int unsigned CL_LVAL_BIT = 24;
    localparam int unsigned CL_PIX_W    = 24;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        WAIT_FRAME,
        IN_FRAME,
        DROP
    } cl_state_e;

    // FIFO entry, MSB first: {tuser, tlast, tdata}
    typedef struct packed {
        logic                tuser;
        logic                tlast;
        logic [CL_PIX_W-1:0] tdata;
    } cl_beat_t;

endpackage

// File: rtl/cl_axis_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk/rst_n (async active-low), wr_en/wr_data push, rd_en pop,
//        rd_data head entry (valid while !empty), full/empty flags.
// A write while full is accepted only if a read happens in the same cycle.
module cl_axis_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_wr_c, do_rd_c;

    // Extra pointer MSB distinguishes full from empty
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_rd_c  = rd_en & ~empty;
        do_wr_c  = wr_en & (~full | do_rd_c);
        if (do_wr_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_rd_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/cl_to_axis_video.sv
// Camera Link base-config word to AXI4-Stream video (same clock domain).
// Ports: CL_clk, CL_rstn (async active-low), CL_data {spare,DVAL,FVAL,LVAL,pixel};
//        m_axis_* stream out (tuser = start of frame, tlast = end of line);
//        overflow sticky drop flag; frame_width/frame_height/stats_valid frame stats.
// Optional feature: define CL_FRAME_STATS_EN to build the frame size counters;
// otherwise the stats outputs are tied to 0.
module cl_to_axis_video
    import cl_video_pkg::*;
#(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 CL_clk,
    input  logic                 CL_rstn,
    input  logic [CL_WORD_W-1:0] CL_data,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 overflow,
    output logic [CNT_W-1:0]     frame_width,
    output logic [CNT_W-1:0]     frame_height,
    output logic                 stats_valid
);
    localparam int unsigned FIFO_W = DATA_W + 2;

    logic [DATA_W-1:0] r_pix_q, r_pix_d;
    logic              r_dval_q, r_dval_d, r_fval_q, r_fval_d, r_lval_q, r_lval_d;
    logic              r_vld_q, r_vld_d, prev_fval_q, prev_fval_d, prev_lval_q, prev_lval_d;
    cl_state_e         state_q, state_d;
    logic              sof_q, sof_d, ovf_q, ovf_d;
    logic              hold_vld_q, hold_vld_d, hold_tuser_q, hold_tuser_d;
    logic [DATA_W-1:0] hold_pix_q, hold_pix_d;
    logic              fval_rise_c, fval_fall_c, lval_fall_c;
    logic              start_c, pix_c, flush_c, push_c, drop_c;
    logic              fifo_wr_c, fifo_rd_c, fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata_c, fifo_rdata;
    logic              unused_spare;

    assign unused_spare = CL_data[CL_WORD_W-1];

    // Input stage R and its one-cycle history for edge detection
    always_comb begin
        r_pix_d     = CL_data[DATA_W-1:0];
        r_dval_d    = CL_data[CL_DVAL_BIT];
        r_fval_d    = CL_data[CL_FVAL_BIT];
        r_lval_d    = CL_data[CL_LVAL_BIT];
        r_vld_d     = 1'b1;
        prev_fval_d = r_fval_q;
        prev_lval_d = r_lval_q;
    end

    assign fval_rise_c = r_fval_q & ~prev_fval_q;
    assign fval_fall_c = ~r_fval_q & prev_fval_q;
    assign lval_fall_c = ~r_lval_q & prev_lval_q;

    // Frame tracking, hold register and FIFO write control
    always_comb begin
        state_d      = state_q;
        sof_d        = sof_q;
        ovf_d        = ovf_q;
        hold_vld_d   = hold_vld_q;
        hold_tuser_d = hold_tuser_q;
        hold_pix_d   = hold_pix_q;

        // A pixel in the FVAL-rise cycle already belongs to the new frame
        start_c  = (state_q == WAIT_FRAME) && fval_rise_c;
        pix_c    = ((state_q == IN_FRAME) || start_c) && r_fval_q && r_lval_q && r_dval_q;
        flush_c  = (state_q == IN_FRAME) && hold_vld_q && (lval_fall_c || fval_fall_c);
        push_c   = hold_vld_q && (pix_c || flush_c);
        fifo_wdata_c = {hold_tuser_q, flush_c, hold_pix_q};
        fifo_wr_c    = push_c && (!fifo_full || fifo_rd_c);
        drop_c       = push_c && fifo_full && !fifo_rd_c;

        if (start_c) begin
            sof_d = 1'b1;
        end

        if (drop_c) begin
            hold_vld_d = 1'b0;
            ovf_d      = 1'b1;
        end else if (pix_c) begin
            hold_vld_d   = 1'b1;
            hold_pix_d   = r_pix_q;
            hold_tuser_d = sof_q || start_c;
            sof_d        = 1'b0;
        end else if (flush_c) begin
            hold_vld_d = 1'b0;
        end

        unique case (state_q)
            WAIT_IDLE:  if (r_vld_q && !r_fval_q) state_d = WAIT_FRAME;
            WAIT_FRAME: if (fval_rise_c)          state_d = IN_FRAME;
            IN_FRAME: begin
                if (fval_fall_c)  state_d = WAIT_FRAME;
                else if (drop_c)  state_d = DROP;
            end
            DROP:       if (fval_fall_c)          state_d = WAIT_FRAME;
            default:                              state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge CL_clk or negedge CL_rstn) begin
        if (!CL_rstn) begin
            r_pix_q      <= '0;
            r_dval_q     <= 1'b0;
            r_fval_q     <= 1'b0;
            r_lval_q     <= 1'b0;
            r_vld_q      <= 1'b0;
            prev_fval_q  <= 1'b0;
            prev_lval_q  <= 1'b0;
            state_q      <= WAIT_IDLE;
            sof_q        <= 1'b1;
            ovf_q        <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_tuser_q <= 1'b0;
            hold_pix_q   <= '0;
        end else begin
            r_pix_q      <= r_pix_d;
            r_dval_q     <= r_dval_d;
            r_fval_q     <= r_fval_d;
            r_lval_q     <= r_lval_d;
            r_vld_q      <= r_vld_d;
            prev_fval_q  <= prev_fval_d;
            prev_lval_q  <= prev_lval_d;
            state_q      <= state_d;
            sof_q        <= sof_d;
            ovf_q        <= ovf_d;
            hold_vld_q   <= hold_vld_d;
            hold_tuser_q <= hold_tuser_d;
            hold_pix_q   <= hold_pix_d;
        end
    end

    assign fifo_rd_c = m_axis_tready & ~fifo_empty;

    cl_axis_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CL_clk),
        .rst_n   (CL_rstn),
        .wr_en   (fifo_wr_c),
        .wr_data (fifo_wdata_c),
        .rd_en   (fifo_rd_c),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = fifo_rdata;
    assign m_axis_tvalid = ~fifo_empty;
    assign overflow      = ovf_q;

`ifdef CL_FRAME_STATS_EN
    logic [CNT_W-1:0] line_px_q, line_px_d, line_cnt_q, line_cnt_d, first_w_q, first_w_d;
    logic [CNT_W-1:0] fw_q, fw_d, fh_q, fh_d;
    logic             first_done_q, first_done_d, stv_q, stv_d, line_close_c;

    // Per-line pixel count and per-frame non-empty line count, saturating
    always_comb begin
        line_px_d    = start_c ? '0 : line_px_q;
        line_cnt_d   = start_c ? '0 : line_cnt_q;
        first_done_d = start_c ? 1'b0 : first_done_q;
        first_w_d    = first_w_q;
        fw_d         = fw_q;
        fh_d         = fh_q;
        stv_d        = 1'b0;
        line_close_c = (state_q == IN_FRAME) && (lval_fall_c || fval_fall_c) && (line_px_q != '0);

        if (pix_c && (line_px_d != '1)) begin
            line_px_d = line_px_d + CNT_W'(1);
        end
        if (line_close_c) begin
            if (line_cnt_q != '1) line_cnt_d = line_cnt_q + CNT_W'(1);
            line_px_d = '0;
            if (!first_done_q) begin
                first_w_d    = line_px_q;
                first_done_d = 1'b1;
            end
        end
        // Publish only for a clean, non-empty frame
        if ((state_q == IN_FRAME) && fval_fall_c && !drop_c && (line_cnt_d != '0)) begin
            fw_d  = first_w_d;
            fh_d  = line_cnt_d;
            stv_d = 1'b1;
        end
    end

    always_ff @(posedge CL_clk or negedge CL_rstn) begin
        if (!CL_rstn) begin
            line_px_q    <= '0;
            line_cnt_q   <= '0;
            first_w_q    <= '0;
            first_done_q <= 1'b0;
            fw_q         <= '0;
            fh_q         <= '0;
            stv_q        <= 1'b0;
        end else begin
            line_px_q    <= line_px_d;
            line_cnt_q   <= line_cnt_d;
            first_w_q    <= first_w_d;
            first_done_q <= first_done_d;
            fw_q         <= fw_d;
            fh_q         <= fh_d;
            stv_q        <= stv_d;
        end
    end

    assign frame_width  = fw_q;
    assign frame_height = fh_q;
    assign stats_valid  = stv_q;
`else
    assign frame_width  = '0;
    assign frame_height = '0;
    assign stats_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_cl_to_axis_video.sv
// Scoreboard bench for cl_to_axis_video: expected beats are queued as
// pixels are driven and compared as the stream delivers them.
`timescale 1ns/1ps
module tb_cl_to_axis_video;
    import cl_video_pkg::*;

    localparam int unsigned DATA_W     = 24;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned CNT_W      = 16;

    logic              CL_clk = 1'b0;
    logic              CL_rstn;
    logic [27:0]       CL_data;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tuser;
    logic              m_axis_tlast;
    logic              overflow;
    logic [CNT_W-1:0]  frame_width;
    logic [CNT_W-1:0]  frame_height;
    logic              stats_valid;

    cl_to_axis_video #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .CL_clk        (CL_clk),
        .CL_rstn       (CL_rstn),
        .CL_data       (CL_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .frame_width   (frame_width),
        .frame_height  (frame_height),
        .stats_valid   (stats_valid)
    );

    always #5 CL_clk = ~CL_clk;

    int                checks   = 0;
    int                failures = 0;
    int                sv_total = 0;
    int                sv_base  = 0;
    cl_beat_t          exp_q[$];
    cl_beat_t          mon_e;
    logic [DATA_W-1:0] pix_val;
    logic              sof_model;
`ifdef CL_FRAME_STATS_EN
    logic [CNT_W-1:0]  last_fw = '0;
    logic [CNT_W-1:0]  last_fh = '0;
`endif

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Stream monitor: every accepted beat is checked against the queue head
    always @(negedge CL_clk) begin
        if (CL_rstn && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("beat_tdata", 32'(m_axis_tdata), 32'(mon_e.tdata));
                check_val("beat_tuser", 32'(m_axis_tuser), 32'(mon_e.tuser));
                check_val("beat_tlast", 32'(m_axis_tlast), 32'(mon_e.tlast));
            end
        end
    end

    always @(negedge CL_clk) begin
        if (stats_valid) begin
            sv_total++;
`ifdef CL_FRAME_STATS_EN
            last_fw = frame_width;
            last_fh = frame_height;
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic f, input logic l, input logic d);
        @(posedge CL_clk);
        #1;
        CL_data = {1'b0, d, f, l, pix_val};
    endtask

    task automatic frame_start();
        sof_model = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic frame_end();
        repeat (4) drive(1'b0, 1'b0, 1'b0);
    endtask

    // One line of px cycles; cycles slo..shi carry DVAL=0.
    // fval_after=0 drops FVAL together with LVAL after the last pixel.
    task automatic send_line(input int px, input int slo, input int shi,
                             input bit exp, input bit fval_after);
        int       last_v;
        bit       dv;
        cl_beat_t e;
        last_v = -1;
        for (int i = 0; i < px; i++) begin
            if (!(i >= slo && i <= shi)) last_v = i;
        end
        for (int i = 0; i < px; i++) begin
            dv      = !(i >= slo && i <= shi);
            pix_val = pix_val + DATA_W'(1);
            drive(1'b1, 1'b1, dv);
            if (dv) begin
                if (exp) begin
                    e.tuser = sof_model;
                    e.tlast = (i == last_v);
                    e.tdata = pix_val;
                    exp_q.push_back(e);
                end
                sof_model = 1'b0;
            end
        end
        repeat (2) drive(fval_after, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge CL_clk);
            n++;
        end
        check_val({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge CL_clk);
        check_val({tag, "_tvalid_idle"}, 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        CL_rstn       = 1'b0;
        CL_data       = '0;
        m_axis_tready = 1'b1;
        pix_val       = '0;
        sof_model     = 1'b1;

        // Reset state
        repeat (3) @(negedge CL_clk);
        check_val("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
        check_val("rst_tuser",    32'(m_axis_tuser),  32'd0);
        check_val("rst_tlast",    32'(m_axis_tlast),  32'd0);
        check_val("rst_tdata",    32'(m_axis_tdata),  32'd0);
        check_val("rst_overflow", 32'(overflow),      32'd0);
        check_val("rst_stats_v",  32'(stats_valid),   32'd0);
        check_val("rst_fwidth",   32'(frame_width),   32'd0);
        check_val("rst_fheight",  32'(frame_height),  32'd0);
        check_val("rst_state",    32'(dut.state_q),   32'(WAIT_IDLE));
        @(posedge CL_clk);
        #1;
        CL_rstn = 1'b1;

        // 4 lines x 8 px, running count
        frame_start();
        repeat (4) send_line(8, -1, -1, 1'b1, 1'b1);
        frame_end();
        wait_drain("t1");
        check_val("t1_overflow", 32'(overflow), 32'd0);

        // DVAL low on px 3..4
        frame_start();
        send_line(8, 3, 4, 1'b1, 1'b1);
        frame_end();
        wait_drain("t3");

        // FVAL falls with LVAL on the last pixel
        frame_start();
        send_line(4, -1, -1, 1'b1, 1'b1);
        send_line(5, -1, -1, 1'b1, 1'b0);
        frame_end();
        wait_drain("t5a");

        // Frame with FVAL high but no valid pixel
        frame_start();
        repeat (8) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        frame_end();
        repeat (6) @(negedge CL_clk);
        check_val("t5_empty_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("t5_sof_pending",  32'(dut.sof_q),     32'd1);
        frame_start();
        send_line(3, -1, -1, 1'b1, 1'b1);
        frame_end();
        wait_drain("t5b");

        // Back-pressure overflow: only the first line fits the FIFO
        @(posedge CL_clk);
        #1;
        m_axis_tready = 1'b0;
        frame_start();
        send_line(16, -1, -1, 1'b1, 1'b1);
        send_line(16, -1, -1, 1'b0, 1'b1);
        @(negedge CL_clk);
        check_val("t4_overflow", 32'(overflow),    32'd1);
        check_val("t4_state",    32'(dut.state_q), 32'(DROP));
        check_val("t4_qsize",    32'(exp_q.size()), 32'(FIFO_DEPTH));
        repeat (3) begin
            @(negedge CL_clk);
            check_val("t4_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
            check_val("t4_hold_tdata",  32'(m_axis_tdata),  32'(exp_q[0].tdata));
            check_val("t4_hold_tuser",  32'(m_axis_tuser),  32'(exp_q[0].tuser));
        end
        frame_end();
        @(posedge CL_clk);
        #1;
        m_axis_tready = 1'b1;
        wait_drain("t4a");
        frame_start();
        send_line(16, -1, -1, 1'b1, 1'b1);
        send_line(16, -1, -1, 1'b1, 1'b1);
        frame_end();
        wait_drain("t4b");

        // Reset in the middle of a frame
        @(posedge CL_clk);
        #1;
        m_axis_tready = 1'b0;
        frame_start();
        repeat (3) begin
            pix_val = pix_val + DATA_W'(1);
            drive(1'b1, 1'b1, 1'b1);
        end
        CL_rstn = 1'b0;
        repeat (3) begin
            pix_val = pix_val + DATA_W'(1);
            drive(1'b1, 1'b1, 1'b1);
        end
        check_val("t2_rst_overflow", 32'(overflow), 32'd0);
        CL_rstn = 1'b1;
        repeat (6) begin
            pix_val = pix_val + DATA_W'(1);
            drive(1'b1, 1'b1, 1'b1);
        end
        m_axis_tready = 1'b1;
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge CL_clk);
            check_val("t2_no_beats", 32'(m_axis_tvalid), 32'd0);
        end
        frame_end();
        frame_start();
        send_line(6, -1, -1, 1'b1, 1'b1);
        frame_end();
        wait_drain("t2");

        // Frame statistics, 3 lines x 10 px
        sv_base = sv_total;
        frame_start();
        repeat (3) send_line(10, -1, -1, 1'b1, 1'b1);
        frame_end();
        wait_drain("t6");
`ifdef CL_FRAME_STATS_EN
        check_val("t6_stats_pulses", 32'(sv_total - sv_base), 32'd1);
        check_val("t6_fwidth",       32'(last_fw),            32'd10);
        check_val("t6_fheight",      32'(last_fh),            32'd3);
`else
        check_val("t6_stats_pulses", 32'(sv_total),     32'd0);
        check_val("t6_fwidth",       32'(frame_width),  32'd0);
        check_val("t6_fheight",      32'(frame_height), 32'd0);
`endif

        check_val("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
